mem_bus_decoder: RTL and testbench

- Parametrised successor to the single-SRAM wrapper. Decodes the PicoRV32 native memory interface onto NUM_SLAVES address regions, each forwarded to its own slave port.
- Registers the request and holds it until the selected slave completes. Returns a registered one-cycle response to the core.
- Adds behaviour the single-region wrapper lacks: a per-access timeout, a defined error response for unmapped or stalled accesses, and sticky error capture for software and debug.

---
 rtl/mem_bus_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_mem_bus_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_decoder.sv
// Address decoder bridging the PicoRV32 native memory interface onto NUM_SLAVES regions,
// with per-access timeout, error responses and sticky first-error capture.
module mem_bus_decoder #(
    parameter int unsigned                  NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0]     BASE_ADDRS     = {32'h3000_0000, 32'h2000_0000,
                                                              32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*8-1:0]      SIZE_LOG2      = {8'd12, 8'd12, 8'd12, 8'd15},
    parameter int unsigned                  TIMEOUT_CYCLES = 255,
    parameter logic [31:0]                  ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_wdata,
    input  logic [3:0]                  mem_wstrb,
    output logic [31:0]                 mem_rdata,
    output logic [NUM_SLAVES-1:0]       s_valid,
    input  logic [NUM_SLAVES-1:0]       s_ready,
    output logic [31:0]                 s_addr,
    output logic [31:0]                 s_wdata,
    output logic [3:0]                  s_wstrb,
    input  logic [NUM_SLAVES*32-1:0]    s_rdata,
    input  logic                        err_clr,
    output logic                        err_valid,
    output logic [1:0]                  err_cause,
    output logic [31:0]                 err_addr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]             state, state_n;
    logic                   err_pend, err_pend_n;
    logic                   req_wr, req_wr_n;
    logic [31:0]            req_addr, req_addr_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   mem_ready_n;
    logic [31:0]            mem_rdata_n;
    logic [NUM_SLAVES-1:0]  s_valid_n;
    logic [31:0]            s_addr_n, s_wdata_n;
    logic [3:0]             s_wstrb_n;
    logic                   err_valid_n;
    logic [1:0]             err_cause_n;
    logic [31:0]            err_addr_n;

    logic [NUM_SLAVES-1:0]  hit_vec;
    logic [31:0]            hit_base;
    logic                   hit_any;
    logic                   sel_ready;
    logic [31:0]            sel_rdata;
    logic                   err_load;
    logic [1:0]             err_cause_in;
    logic [31:0]            err_addr_in;

    // Region decode; iterating downward lets the lowest matching index win.
    always_comb begin
        hit_vec  = '0;
        hit_base = '0;
        hit_any  = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem_addr >> SIZE_LOG2[i*8 +: 8]) ==
                (BASE_ADDRS[i*32 +: 32] >> SIZE_LOG2[i*8 +: 8])) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                hit_base   = BASE_ADDRS[i*32 +: 32];
                hit_any    = 1'b1;
            end
        end
    end

    // The one-hot s_valid register doubles as the selected-slave index.
    always_comb begin
        sel_ready = |(s_ready & s_valid);
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_valid[i]) begin
                sel_rdata = s_rdata[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            err_pend  <= 1'b0;
            req_wr    <= 1'b0;
            req_addr  <= '0;
            cnt       <= '0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            s_valid   <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_wstrb   <= '0;
            err_valid <= 1'b0;
            err_cause <= '0;
            err_addr  <= '0;
        end else begin
            state     <= state_n;
            err_pend  <= err_pend_n;
            req_wr    <= req_wr_n;
            req_addr  <= req_addr_n;
            cnt       <= cnt_n;
            mem_ready <= mem_ready_n;
            mem_rdata <= mem_rdata_n;
            s_valid   <= s_valid_n;
            s_addr    <= s_addr_n;
            s_wdata   <= s_wdata_n;
            s_wstrb   <= s_wstrb_n;
            err_valid <= err_valid_n;
            err_cause <= err_cause_n;
            err_addr  <= err_addr_n;
        end
    end

    always_comb begin
        state_n      = state;
        err_pend_n   = err_pend;
        req_wr_n     = req_wr;
        req_addr_n   = req_addr;
        cnt_n        = cnt;
        mem_ready_n  = 1'b0;
        mem_rdata_n  = mem_rdata;
        s_valid_n    = s_valid;
        s_addr_n     = s_addr;
        s_wdata_n    = s_wdata;
        s_wstrb_n    = s_wstrb;
        err_valid_n  = err_valid;
        err_cause_n  = err_cause;
        err_addr_n   = err_addr;
        err_load     = 1'b0;
        err_cause_in = '0;
        err_addr_in  = '0;

        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    req_wr_n   = |mem_wstrb;
                    req_addr_n = mem_addr;
                    if (hit_any) begin
                        s_valid_n = hit_vec;
                        s_addr_n  = mem_addr - hit_base;
                        s_wdata_n = mem_wdata;
                        s_wstrb_n = mem_wstrb;
                        cnt_n     = '0;
                        state_n   = ST_ACCESS;
                    end else begin
                        err_load     = 1'b1;
                        err_cause_in = CAUSE_UNMAPPED;
                        err_addr_in  = mem_addr;
                        err_pend_n   = 1'b1;
                        state_n      = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    mem_rdata_n = req_wr ? 32'h0 : sel_rdata;
                    mem_ready_n = 1'b1;
                    s_valid_n   = '0;
                    state_n     = ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                    s_valid_n    = '0;
                    err_load     = 1'b1;
                    err_cause_in = CAUSE_TIMEOUT;
                    err_addr_in  = req_addr;
                    err_pend_n   = 1'b1;
                    state_n      = ST_ERR;
                end else if (cnt != CNT_MAX) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                // First ERR cycle records the error; the second one carries the response.
                if (err_pend) begin
                    mem_ready_n = 1'b1;
                    mem_rdata_n = req_wr ? 32'h0 : ERR_RDATA;
                    err_pend_n  = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
        endcase

        // Sticky capture keeps the first error; a simultaneous clear lets the new one in.
        if (err_load && (!err_valid || err_clr)) begin
            err_valid_n = 1'b1;
            err_cause_n = err_cause_in;
            err_addr_n  = err_addr_in;
        end else if (err_clr) begin
            err_valid_n = 1'b0;
            err_cause_n = '0;
            err_addr_n  = '0;
        end
    end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder: table of access vectors plus hand sequences for
// error clear races and reset during an access.
module tb_mem_bus_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_valid;
    logic         mem_ready;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic [31:0]  mem_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [127:0] s_rdata;
    logic         err_clr;
    logic         err_valid;
    logic [1:0]   err_cause;
    logic [31:0]  err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_bus_decoder #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rdata   (s_rdata),
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_cause (err_cause),
        .err_addr  (err_addr)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        clr;        // pulse err_clr before the request
        int          ready_at;   // observation index where the slave answers, 0 = never
        logic [3:0]  exp_sv;
        logic [31:0] exp_saddr;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_svcnt;
        logic        exp_ev;
        logic [1:0]  exp_cause;
        logic [31:0] exp_eaddr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and follow it to its response, observing on falling edges.
    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          svcnt;
        logic [31:0] rd;
        string       tag;
        lat   = 0;
        svcnt = 0;
        rd    = '0;
        tag   = $sformatf("v%0d", idx);
        if (v.clr) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
        end
        mem_valid = 1'b1;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                mem_valid = 1'b0;
                mem_addr  = 32'hFFFF_FFF0;
                mem_wdata = 32'h0BAD_0BAD;
                mem_wstrb = 4'hF;
                check({tag, " s_valid"}, 32'(s_valid), 32'(v.exp_sv));
                if (v.exp_sv != 4'b0000) begin
                    check({tag, " s_addr"}, s_addr, v.exp_saddr);
                    check({tag, " s_wdata"}, s_wdata, v.wdata);
                    check({tag, " s_wstrb"}, 32'(s_wstrb), 32'(v.wstrb));
                end
            end
            if (s_valid != 4'b0000) svcnt++;
            if (mem_ready) begin
                lat = n;
                rd  = mem_rdata;
            end
            // Non-selected slaves are held ready to show they are ignored.
            s_ready = (n == v.ready_at) ? v.exp_sv : ~v.exp_sv;
        end
        s_ready = '0;
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " rdata"}, rd, v.exp_rdata);
        check({tag, " s_valid cycles"}, 32'(svcnt), 32'(v.exp_svcnt));
        @(negedge clk);
        check({tag, " ready pulse"}, 32'(mem_ready), 32'h0);
        check({tag, " rdata hold"}, mem_rdata, v.exp_rdata);
        check({tag, " err_valid"}, 32'(err_valid), 32'(v.exp_ev));
        check({tag, " err_cause"}, 32'(err_cause), 32'(v.exp_cause));
        check({tag, " err_addr"}, err_addr, v.exp_eaddr);
    endtask

    initial begin
        //          addr          wdata         wstrb  clr  rdy  sv      saddr        lat rdata         svc ev    cause  eaddr
        vecs[0] = '{32'h1000_0010, 32'h0,        4'h0, 1'b0, 3, 4'b0010, 32'h10,      4, 32'h1234_5678, 3, 1'b0, 2'b00, 32'h0};
        vecs[1] = '{32'h0000_7FFC, 32'hA5A5_A5A5, 4'h3, 1'b0, 1, 4'b0001, 32'h7FFC,   2, 32'h0,         1, 1'b0, 2'b00, 32'h0};
        vecs[2] = '{32'h2000_0004, 32'h0,        4'h0, 1'b0, 4, 4'b0100, 32'h4,       5, 32'h3333_3333, 4, 1'b0, 2'b00, 32'h0};
        vecs[3] = '{32'h0000_8000, 32'h0,        4'h0, 1'b0, 0, 4'b0000, 32'h0,       2, 32'hDEAD_BEEF, 0, 1'b1, 2'b01, 32'h0000_8000};
        vecs[4] = '{32'h3000_0100, 32'h0,        4'h0, 1'b0, 0, 4'b1000, 32'h100,     6, 32'hDEAD_BEEF, 4, 1'b1, 2'b01, 32'h0000_8000};
        vecs[5] = '{32'h4000_0000, 32'h5555_0000, 4'hF, 1'b0, 0, 4'b0000, 32'h0,      2, 32'h0,         0, 1'b1, 2'b01, 32'h0000_8000};
        vecs[6] = '{32'h2000_0000, 32'h0,        4'h0, 1'b1, 0, 4'b0100, 32'h0,       6, 32'hDEAD_BEEF, 4, 1'b1, 2'b10, 32'h2000_0000};

        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        s_ready   = '0;
        s_rdata   = {32'h4444_4444, 32'h3333_3333, 32'h1234_5678, 32'h0000_1111};
        err_clr   = 1'b0;

        repeat (3) @(negedge clk);
        check("reset mem_ready", 32'(mem_ready), 32'h0);
        check("reset mem_rdata", mem_rdata, 32'h0);
        check("reset s_valid", 32'(s_valid), 32'h0);
        check("reset s_addr", s_addr, 32'h0);
        check("reset s_wdata", s_wdata, 32'h0);
        check("reset s_wstrb", 32'(s_wstrb), 32'h0);
        check("reset err_valid", 32'(err_valid), 32'h0);
        check("reset err_cause", 32'(err_cause), 32'h0);
        check("reset err_addr", err_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // Clear and a fresh unmapped error in the same cycle: the new error is loaded.
        err_clr   = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = 32'h5000_0000;
        mem_wstrb = 4'h0;
        @(negedge clk);
        err_clr   = 1'b0;
        mem_valid = 1'b0;
        check("clr+err err_valid", 32'(err_valid), 32'h1);
        check("clr+err err_cause", 32'(err_cause), 32'h1);
        check("clr+err err_addr", err_addr, 32'h5000_0000);
        check("clr+err no ready", 32'(mem_ready), 32'h0);
        @(negedge clk);
        check("clr+err ready", 32'(mem_ready), 32'h1);
        check("clr+err rdata", mem_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr err_valid", 32'(err_valid), 32'h0);
        check("clr err_cause", 32'(err_cause), 32'h0);
        check("clr err_addr", err_addr, 32'h0);

        // Reset in the middle of an access aborts it without a response.
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0000;
        mem_wstrb = 4'h0;
        @(negedge clk);
        mem_valid = 1'b0;
        check("pre-reset s_valid", 32'(s_valid), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("async reset s_valid", 32'(s_valid), 32'h0);
        check("async reset mem_ready", 32'(mem_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset mem_ready", 32'(mem_ready), 32'h0);
        check("post-reset s_valid", 32'(s_valid), 32'h0);
        run_vec(7, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
